// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int SRAM_DW = 16;
  localparam int CNT_W = 3;
endpackage

// File: rtl/sram_controller.sv
// MEM-stage 32-bit load/store carried out as two half-word accesses on a 16-bit async SRAM.
// Optional macro SRAM_ADDR_CHECK_EN adds range checking and the sticky addr_err output.
module sram_controller
  import sram_pkg::*;
#(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]      BASE      = 32'(BASE_ADDR);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               is_write_reg, is_write_next;
  logic [SRAM_AW-2:0] word_reg, word_next;
  logic [SRAM_DW-1:0] wdata_hi_reg, wdata_hi_next;
  logic [31:0]        read_data_reg, read_data_next;
  logic [SRAM_AW-1:0] sram_addr_reg, sram_addr_next;
  logic               we_n_reg, we_n_next;
  logic               drive_reg, drive_next;
  logic [SRAM_DW-1:0] dq_out_reg, dq_out_next;
  logic [31:0]        offset;
  logic               req;
  logic               unused_bits;

  assign req         = rd_en | wr_en;
  assign offset      = address - BASE;
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
  localparam logic [31:0] WORD_LIMIT = 32'(1) << (SRAM_AW - 1);
  logic err_reg, err_next, bad_req;
  assign bad_req  = (address < BASE) || ((offset >> 2) >= WORD_LIMIT) || (address[1:0] != 2'b00);
  assign addr_err = err_reg;
`endif

  assign read_data = read_data_reg;
  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_WE_N = we_n_reg;
  assign SRAM_DQ   = drive_reg ? dq_out_reg : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      is_write_reg  <= 1'b0;
      word_reg      <= '0;
      wdata_hi_reg  <= '0;
      read_data_reg <= '0;
      sram_addr_reg <= '0;
      we_n_reg      <= 1'b1;
      drive_reg     <= 1'b0;
      dq_out_reg    <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      is_write_reg  <= is_write_next;
      word_reg      <= word_next;
      wdata_hi_reg  <= wdata_hi_next;
      read_data_reg <= read_data_next;
      sram_addr_reg <= sram_addr_next;
      we_n_reg      <= we_n_next;
      drive_reg     <= drive_next;
      dq_out_reg    <= dq_out_next;
`ifdef SRAM_ADDR_CHECK_EN
      err_reg       <= err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    is_write_next  = is_write_reg;
    word_next      = word_reg;
    wdata_hi_next  = wdata_hi_reg;
    read_data_next = read_data_reg;
    sram_addr_next = sram_addr_reg;
    we_n_next      = we_n_reg;
    drive_next     = drive_reg;
    dq_out_next    = dq_out_reg;
    ready          = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    err_next       = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        ready = !req;
        if (req) begin
          is_write_next = wr_en;
          word_next     = offset[SRAM_AW:2];
          wdata_hi_next = write_data[31:16];
          cnt_next      = '0;
`ifdef SRAM_ADDR_CHECK_EN
          if (bad_req) begin
            // Rejected request: skip the SRAM entirely and finish next cycle.
            state_next = DONE;
            err_next   = 1'b1;
            if (!wr_en) read_data_next = '0;
          end else
`endif
          begin
            // Outputs are registered, so the low half is presented as LO begins.
            state_next     = LO;
            sram_addr_next = {offset[SRAM_AW:2], 1'b0};
            we_n_next      = !wr_en;
            drive_next     = wr_en;
            dq_out_next    = write_data[15:0];
          end
        end
      end
      LO: begin
        if (cnt_reg == WAIT_LAST) begin
          cnt_next       = '0;
          state_next     = HI;
          sram_addr_next = {word_reg, 1'b1};
          dq_out_next    = wdata_hi_reg;
          if (!is_write_reg) read_data_next[15:0] = SRAM_DQ;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HI: begin
        if (cnt_reg == WAIT_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
          we_n_next  = 1'b1;
          drive_next = 1'b0;
          if (!is_write_reg) read_data_next[31:16] = SRAM_DQ;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory back end that replaces the single-cycle RAM behind the MEM stage with an external 16-bit asynchronous SRAM. Accepts one 32-bit load or store from the MEM stage, splits it into two half-word SRAM accesses with programmable wait states, and holds `ready` low so the pipeline freezes until the word is done. Sits between the MEM stage (upstream) and the SRAM pins/model (downstream).

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 1: extra cycles held per half-word access (0..7).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_en`  in  1  load request from MEM stage.
- `wr_en`  in  1  store request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data.
- `read_data`  out  32  load data, registered.
- `ready`  out  1  low = freeze pipeline.
- `SRAM_ADDR`  out  SRAM_AW  half-word address.
- `SRAM_DQ`  inout  16  data bus; Hi-Z unless writing.
- `SRAM_WE_N`  out  1  write strobe, active-low.
- `addr_err`  out  1  only with `SRAM_ADDR_CHECK_EN`; sticky range error.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: if `wr_en|rd_en`, latch op (`wr_en` wins if both high), word index `(address-BASE_ADDR)>>2`, and `write_data`; go to LO. `ready` = `!(rd_en|wr_en)` (combinational in IDLE only).
- LO: `SRAM_ADDR={word,1'b0}`; writes drive `write_data[15:0]` and hold `SRAM_WE_N=0`. Stays `WAIT_CYCLES+1` cycles (3-bit counter), then HI. Reads capture `SRAM_DQ` into `read_data[15:0]` on the last LO edge.
- HI: same with `{word,1'b1}` and bits [31:16]; then DONE.
- DONE: `ready=1` for exactly one cycle, `SRAM_WE_N=1`, bus Hi-Z; go to IDLE.
- Inputs are ignored outside IDLE: dropping or changing a request mid-transaction does not abort it.
- Back-to-back accesses: a request still high in the cycle after DONE starts a new transaction from IDLE.
- Stores leave `read_data` unchanged. Without the config macro, the word index is truncated to `SRAM_AW-1` bits and `address[1:0]` is ignored.

## Timing
- Reset values: state IDLE, `read_data=0`, `SRAM_WE_N=1`, `SRAM_DQ` Hi-Z, `SRAM_ADDR=0`, counter 0, `addr_err=0`. While a request is high in IDLE, `ready=0`.
- A request seen in IDLE at cycle 0 follows this schedule: LO in cycles 1..W+1, HI in W+2..2W+2, DONE (`ready=1`) in cycle 2W+3. With the default W=1, `ready` rises in cycle 5.
- Total stall is 2W+3 cycles per access. Load data is valid from DONE and is held until the next load completes.
- Reset asserted mid-transaction: immediate return to the reset values, and any partial write half is abandoned. After reset deasserts, the request (if still high) restarts from IDLE.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined: the `addr_err` port exists. If a request in IDLE has `address<BASE_ADDR`, a word index ≥ 2^(SRAM_AW-1), or `address[1:0]!=0`, the SRAM is never touched. The controller goes IDLE→DONE (`ready` in cycle 1). A load returns `read_data=0`. `addr_err` is set and stays set until `rst`.
- Not defined: no port and no check; truncating behaviour as above.

## Structure
- `sram_pkg`: state enum (IDLE/LO/HI/DONE), `SRAM_DW=16`, counter width constant.
- Single module. No sub-module; the wait counter is inline. The tri-state bus is a continuous assign from registered drive-enable and data.

## Test plan
- Store 0xDEADBEEF at 1024, W=1 → SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD; `ready` low cycles 0–4, high cycle 5.
- Load from 1024 after the above → `read_data=0xDEADBEEF` at DONE; `SRAM_WE_N` stays 1 throughout.
- WAIT_CYCLES=0 then 3: load latency → `ready` in cycle 3 / cycle 9.
- `rd_en` and `wr_en` both high at 1028 → store performed. Request dropped in cycle 2 → transaction still completes, with DONE in cycle 5.
- `rst` pulsed in HI during a store → `SRAM_WE_N=1`, bus Hi-Z, and `read_data=0` immediately. The next store to 1032 completes normally.
- With `SRAM_ADDR_CHECK_EN`: load at 1000 → `ready` in cycle 1, `read_data=0`, `addr_err=1` and still 1 after a following valid access.
